// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered select for an N_REQ-to-1 mux.
// A hold limit forces release so that no single owner can starve the others.
module mux_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic             preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             valid_nxt, preempt_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [SEL_W:0]   pick;
  logic             expire, rel, owner_req;

  // Circular search from start; returns {found, index}. Descending loop so the
  // lowest circular offset is the last (winning) assignment.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [SEL_W-1:0] start);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      valid    <= valid_nxt;
      preempt  <= preempt_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    grant_nxt   = grant;
    valid_nxt   = valid;
    preempt_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    pick        = '0;
    owner_req   = req[sel];
    expire      = (hold_cnt == 4'(MAX_HOLD - 1));
    rel         = 1'b0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[SEL_W]) begin
          sel_nxt   = pick[SEL_W-1:0];
          grant_nxt = ONE << pick[SEL_W-1:0];
          valid_nxt = 1'b1;
          hold_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        rel = done || !owner_req || expire;
        if (!rel) begin
          hold_nxt = hold_cnt + 4'd1;
        end else begin
          // Preempt flags only a pure hold-limit release, even if re-granted.
          preempt_nxt = expire && !done && owner_req;
          ptr_nxt     = sel + SEL_W'(1);
          pick        = rr_pick(req & ~(ONE << sel), sel + SEL_W'(1));
          hold_nxt    = '0;
          if (pick[SEL_W]) begin
            sel_nxt   = pick[SEL_W-1:0];
            grant_nxt = ONE << pick[SEL_W-1:0];
          end else if (!owner_req) begin
            grant_nxt = '0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, hand sequences for async
// reset, then random traffic against a behavioural owner/round-robin model.
module tb_mux_rr_arbiter;
  localparam int N = 8;
  localparam int MAX_HOLD = 4;

  logic       clk, reset, done, valid, preempt;
  logic [7:0] req, grant;
  logic [2:0] sel;

  int compared = 0;
  int mismatched = 0;

  mux_rr_arbiter #(.N_REQ(N), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel), .grant(grant), .valid(valid), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic       done;
    int         sel;
    logic [7:0] grant;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  // Model state: owner index (-1 = none), cycles held including the current one.
  int   m_owner, m_ptr, m_held, m_sel;
  logic m_pre;

  task automatic add(input bit rs, input logic [7:0] r, input logic d, input int s,
                     input logic [7:0] g, input logic v, input logic p);
    vec_t e;
    e.rst = rs; e.req = r; e.done = d; e.sel = s; e.grant = g; e.valid = v; e.pre = p;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int es, input logic [7:0] eg,
                           input logic ev, input logic ep);
    chk({tag, ".sel"}, int'(sel), es);
    chk({tag, ".grant"}, int'(grant), int'(eg));
    chk({tag, ".valid"}, int'(valid), int'(ev));
    chk({tag, ".preempt"}, int'(preempt), int'(ep));
  endtask

  function automatic int first_req(input logic [7:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_pre = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    bit expired, drop;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      w = first_req(r, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_held = 1; end
    end else begin
      drop = !r[m_owner];
      expired = (m_held >= MAX_HOLD);
      if (!d && !drop && !expired) begin
        m_held++;
      end else begin
        m_pre = expired && !d && !drop;
        m_ptr = (m_owner + 1) % N;
        w = first_req(r, m_ptr, m_owner);
        if (w >= 0) begin m_owner = w; m_held = 1; end
        else if (!drop) m_held = 1;
        else m_owner = -1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  initial begin
    reset = 1'b1; req = '0; done = 1'b0;
    // Sole requester: grant, forced release with preempt, immediate re-grant
    add(1, 8'h04, 0, 2, 8'h04, 1, 0);
    add(0, 8'h04, 0, 2, 8'h04, 1, 0);
    add(0, 8'h04, 0, 2, 8'h04, 1, 0);
    add(0, 8'h04, 0, 2, 8'h04, 1, 0);
    add(0, 8'h04, 0, 2, 8'h04, 1, 1);
    add(0, 8'h04, 0, 2, 8'h04, 1, 0);
    // All requesting, done every granted cycle: rotate with wrap
    add(1, 8'hFF, 0, 0, 8'h01, 1, 0);
    for (int i = 1; i <= 8; i++) add(0, 8'hFF, 1, i % 8, 8'(1) << (i % 8), 1, 0);
    // Two requesters sharing via hold limit
    for (int i = 0; i < 4; i++) add(i == 0, 8'h81, 0, 0, 8'h01, 1, 0);
    add(0, 8'h81, 0, 7, 8'h80, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h81, 0, 7, 8'h80, 1, 0);
    add(0, 8'h81, 0, 0, 8'h01, 1, 1);
    // Request drop releases to idle; sel holds; next grant
    add(1, 8'h08, 0, 3, 8'h08, 1, 0);
    add(0, 8'h00, 0, 3, 8'h00, 0, 0);
    add(0, 8'h10, 0, 4, 8'h10, 1, 0);
    // done coinciding with expiry: no preempt; done in idle ignored
    for (int i = 0; i < 4; i++) add(i == 0, 8'h06, 0, 1, 8'h02, 1, 0);
    add(0, 8'h06, 1, 2, 8'h04, 1, 0);
    add(0, 8'h00, 0, 2, 8'h00, 0, 0);
    add(0, 8'h00, 1, 2, 8'h00, 0, 0);

    @(posedge clk); #1;
    check_out("init_rst", 0, 8'h00, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        reset = 1'b1; #1;
        check_out("vec_rst", 0, 8'h00, 0, 0);
        reset = 1'b0; #1;
      end
      req = vecs[i].req; done = vecs[i].done;
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].grant, vecs[i].valid, vecs[i].pre);
    end

    // Async reset mid-grant (owner 5, hold count 2), then re-arbitration
    reset = 1'b1; #1; reset = 1'b0;
    req = 8'h20; done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_out("t5_hold", 5, 8'h20, 1, 0);
    end
    #2 reset = 1'b1; #1;
    check_out("t5_async", 0, 8'h00, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_out("t5_regrant", 5, 8'h20, 1, 0);

    // Random traffic against the model
    reset = 1'b1; #1; reset = 1'b0;
    model_reset();
    req = '0; done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step(req, done);
      #1;
      check_out("rnd", m_sel, (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00,
                m_owner >= 0, m_pre);
      if ($urandom_range(99) == 0) begin
        reset = 1'b1; #1;
        model_reset();
        check_out("rnd_rst", 0, 8'h00, 0, 0);
        reset = 1'b0;
      end
      case ($urandom_range(3))
        0: req = 8'($urandom) & 8'($urandom);
        1: req = 8'(1) << $urandom_range(7);
        2: req = req;
        default: req = 8'($urandom);
      endcase
      done = ($urandom_range(3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and select generator for the 8-to-1 mux.
- Shares one mux output among 8 requesters.
- Drives the mux select from registered arbitration state, so select is glitch-free and only changes at clock edges.
- Bounds ownership with a hold limit so that no requester can starve the others.

Parameters:
- N_REQ, 8: number of requesters (mux inputs); must equal 2**SEL_W.
- SEL_W, 3: select width driven to the mux.
- MAX_HOLD, 4: maximum consecutive cycles one owner may hold a grant before forced release; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  request vector; req[i] high = input i wants the mux output.
- done  input  1  current owner releases the grant this cycle; ignored when valid=0.
- sel  output  SEL_W  mux select = index of current owner; registered.
- grant  output  N_REQ  one-hot owner vector; all zero when valid=0; registered.
- valid  output  1  a grant is active and sel is meaningful.
- preempt  output  1  one-cycle pulse: owner lost grant by MAX_HOLD expiry (not by done/req drop).

Behaviour:
- Reset (async, high):
  - sel=0, grant=0, valid=0, preempt=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
  - Takes effect immediately mid-grant; first arbitration occurs on the first rising edge after reset deasserts.
- State IDLE (valid=0):
  - Each edge, search req circularly starting at ptr: ptr, ptr+1, ..., ptr+7 mod 8.
  - First set bit wins: sel<=winner, grant<=1<<winner, valid<=1, hold_cnt<=0, go to GRANT.
  - If req==0, stay in IDLE.
  - Latency: req sampled at edge t, grant visible after edge t.
- State GRANT (valid=1):
  - Release is evaluated each edge. Release conditions, by priority:
    - (a) reset;
    - (b) done=1;
    - (c) req[sel]=0;
    - (d) hold_cnt==MAX_HOLD-1, i.e. a forced release.
  - No release: hold_cnt<=hold_cnt+1; sel/grant unchanged.
  - On release:
    - ptr<=sel+1 mod 8 (wraps 7->0).
    - Re-arbitrate in the same edge: circular search from sel+1 over req with bit sel masked.
    - Winner found: switch directly, with no idle cycle. sel/grant update, hold_cnt<=0, stay in GRANT.
    - No other requester, and the owner still requests after (b) or (d): re-grant the same owner, hold_cnt<=0.
    - Otherwise: valid<=0, grant<=0, sel holds last value, go to IDLE.
- preempt:
  - Set to 1 for exactly one cycle after an edge where release was caused solely by (d).
  - This applies even if the same owner is re-granted.
  - If done or a req drop coincides with expiry, preempt=0.
- Invariants:
  - grant is always one-hot or zero.
  - grant==0 iff valid==0.
  - sel changes only at edges.
  - Fairness: any continuously asserted req is granted within 7*MAX_HOLD+1 cycles.
- Requests arriving or dropping while another input owns the grant have no effect until the next arbitration.
- done in IDLE: ignored; state unchanged.

Test Plan:
1. Reset, then req=8'b0000_0100 held, done=0:
   - Grant of input 2 visible one edge after req is sampled: sel=2, grant=8'h04, valid=1.
   - Forced release after 4 cycles with preempt pulse.
   - Immediate re-grant of input 2 (sole requester).
2. req=8'hFF held, done pulsed each cycle the grant is valid:
   - sel sequence 0,1,2,...,7,0 (wrap), one grant per cycle.
   - No idle cycles; preempt stays 0.
3. req=8'b1000_0001, ptr=0, done=0, MAX_HOLD=4:
   - sel=0 for 4 cycles, then sel=7 for 4 cycles, then sel=0.
   - preempt pulses at each switch.
4. Owner 3 granted (req=8'h08), then req drops to 8'h00:
   - Next edge: valid=0, grant=0, sel stays 3, preempt=0.
   - Then req=8'h10: sel=4 next edge (ptr=4).
5. Reset asserted asynchronously mid-grant (sel=5, valid=1, hold_cnt=2):
   - Without waiting for a clock edge: valid=0, grant=0, sel=0, preempt=0.
   - After release, req=8'h20: sel=5 one edge later.
6. In GRANT with sel=1 and req=8'b0000_0110:
   - done=1 on the same edge that hold_cnt==3 gives sel=2, preempt=0.
   - done=1 while valid=0 causes no change.
